// File: rtl/hdc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hdc_pkg
// Description : Shared types and helpers for the class hypervector trainer.
// Revision    : 1.0  initial release
// ============================================================================
package hdc_pkg;

  localparam int DIMENSIONS_DEF = 10000;

  localparam logic LABEL_NS = 1'b0;
  localparam logic LABEL_S  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2
  } state_t;

  // Number of CHUNK-wide slices that make up one hypervector.
  function automatic int num_chunks(input int dims, input int chunk);
    return dims / chunk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hv_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : hv_counter_bank
// Description : One class worth of per-dimension saturating counters with a
//               chunk-indexed increment port and chunk-indexed majority output.
// Revision    : 1.0  initial release
// ============================================================================
module hv_counter_bank
  import hdc_pkg::*;
#(
  parameter int DIMENSIONS = 16,
  parameter int CHUNK      = 4,
  parameter int CNT_W      = 8,
  parameter int CIDX_W     = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clr_i,
  input  logic              inc_en_i,
  input  logic [CIDX_W-1:0] chunk_i,
  input  logic [CHUNK-1:0]  inc_bits_i,
  input  logic [CNT_W-1:0]  n_class_i,
  output logic [CHUNK-1:0]  thr_o
);

  localparam int              NUM_CHUNKS = num_chunks(DIMENSIONS, CHUNK);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Counters stored flat: dimension d lives at [d*CNT_W +: CNT_W].
  logic [DIMENSIONS*CNT_W-1:0] cnt_q;
  logic [CHUNK*CNT_W-1:0]      w_sel;

  // Saturating increment of the addressed chunk's counters.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_en_i) begin
      for (int k = 0; k < NUM_CHUNKS; k++) begin
        if (chunk_i == CIDX_W'(k)) begin
          for (int j = 0; j < CHUNK; j++) begin
            if (inc_bits_i[j] && (cnt_q[(k*CHUNK+j)*CNT_W +: CNT_W] != CNT_MAX)) begin
              cnt_q[(k*CHUNK+j)*CNT_W +: CNT_W] <= cnt_q[(k*CHUNK+j)*CNT_W +: CNT_W] + 1'b1;
            end
          end
        end
      end
    end
  end

  // Select the counters of the addressed chunk.
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (chunk_i == CIDX_W'(k)) begin
        w_sel = cnt_q[k*CHUNK*CNT_W +: CHUNK*CNT_W];
      end
    end
  end

  // Majority threshold: 2*cnt > n at CNT_W+1 bits, ties resolve to 0.
  always_comb begin
    thr_o = '0;
    for (int j = 0; j < CHUNK; j++) begin
      thr_o[j] = {w_sel[j*CNT_W +: CNT_W], 1'b0} > {1'b0, n_class_i};
    end
  end

endmodule
`default_nettype wire

// File: rtl/class_hv_trainer.sv
`default_nettype none
// ============================================================================
// Module      : class_hv_trainer
// Description : Bundles labelled training hypervectors into per-class counters
//               and majority-thresholds them into the two class hypervectors.
// Revision    : 1.0  initial release
// ============================================================================
module class_hv_trainer
  import hdc_pkg::*;
#(
  parameter int DIMENSIONS = DIMENSIONS_DEF,
  parameter int CHUNK      = 100,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIMENSIONS-1:0] hv_in,
  input  logic                  label_in,
  input  logic                  clear,
  input  logic                  finalize,
  output logic                  busy,
  output logic                  out_valid,
  output logic [DIMENSIONS-1:0] ns_hv,
  output logic [DIMENSIONS-1:0] s_hv,
  output logic [CNT_W-1:0]      n_ns,
  output logic [CNT_W-1:0]      n_s,
  output logic                  ovf
);

  localparam int                NUM_CHUNKS = num_chunks(DIMENSIONS, CHUNK);
  localparam int                CIDX_W     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CIDX_W-1:0] LAST_CHUNK = CIDX_W'(NUM_CHUNKS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  if ((DIMENSIONS % CHUNK) != 0) begin : g_chunk_check
    $error("DIMENSIONS must be a multiple of CHUNK");
  end

  state_t                state_q;
  logic [CIDX_W-1:0]     chunk_q;
  logic [DIMENSIONS-1:0] hv_q;
  logic                  label_q;
  logic                  drop_q;
  logic [CNT_W-1:0]      n_ns_q;
  logic [CNT_W-1:0]      n_s_q;
  logic                  ovf_q;
  logic                  out_valid_q;
  logic [DIMENSIONS-1:0] ns_hv_q;
  logic [DIMENSIONS-1:0] s_hv_q;

  logic [CHUNK-1:0]      w_hv_chunk;
  logic [CHUNK-1:0]      w_ns_thr;
  logic [CHUNK-1:0]      w_s_thr;
  logic                  w_bank_clr;
  logic                  w_ns_inc;
  logic                  w_s_inc;

  assign in_ready  = (state_q == IDLE) & ~clear & ~finalize;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign ns_hv     = ns_hv_q;
  assign s_hv      = s_hv_q;
  assign n_ns      = n_ns_q;
  assign n_s       = n_s_q;
  assign ovf       = ovf_q;

  // A dropped sample still walks every chunk but touches no counter.
  assign w_bank_clr = (state_q == IDLE) & clear;
  assign w_ns_inc   = (state_q == ACCUM) & (label_q == LABEL_NS) & ~drop_q;
  assign w_s_inc    = (state_q == ACCUM) & (label_q == LABEL_S) & ~drop_q;

  // Slice of the latched sample addressed by the current chunk.
  always_comb begin
    w_hv_chunk = '0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (chunk_q == CIDX_W'(k)) begin
        w_hv_chunk = hv_q[k*CHUNK +: CHUNK];
      end
    end
  end

  hv_counter_bank #(
    .DIMENSIONS (DIMENSIONS),
    .CHUNK      (CHUNK),
    .CNT_W      (CNT_W),
    .CIDX_W     (CIDX_W)
  ) u_ns_bank (
    .clk        (clk),
    .nrst       (nrst),
    .clr_i      (w_bank_clr),
    .inc_en_i   (w_ns_inc),
    .chunk_i    (chunk_q),
    .inc_bits_i (w_hv_chunk),
    .n_class_i  (n_ns_q),
    .thr_o      (w_ns_thr)
  );

  hv_counter_bank #(
    .DIMENSIONS (DIMENSIONS),
    .CHUNK      (CHUNK),
    .CNT_W      (CNT_W),
    .CIDX_W     (CIDX_W)
  ) u_s_bank (
    .clk        (clk),
    .nrst       (nrst),
    .clr_i      (w_bank_clr),
    .inc_en_i   (w_s_inc),
    .chunk_i    (chunk_q),
    .inc_bits_i (w_hv_chunk),
    .n_class_i  (n_s_q),
    .thr_o      (w_s_thr)
  );

  // Control FSM: sample intake, chunk sequencing and class HV write-back.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      chunk_q     <= '0;
      hv_q        <= '0;
      label_q     <= LABEL_NS;
      drop_q      <= 1'b0;
      n_ns_q      <= '0;
      n_s_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      ns_hv_q     <= '0;
      s_hv_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          chunk_q <= '0;
          if (clear) begin
            n_ns_q      <= '0;
            n_s_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
          end else if (finalize) begin
            state_q <= FINAL;
          end else if (in_valid) begin
            hv_q        <= hv_in;
            label_q     <= label_in;
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
            drop_q      <= 1'b0;
            // A full sample counter means the sample cannot be represented.
            if (label_in == LABEL_S) begin
              if (n_s_q == CNT_MAX) begin
                drop_q <= 1'b1;
                ovf_q  <= 1'b1;
              end else begin
                n_s_q <= n_s_q + 1'b1;
              end
            end else begin
              if (n_ns_q == CNT_MAX) begin
                drop_q <= 1'b1;
                ovf_q  <= 1'b1;
              end else begin
                n_ns_q <= n_ns_q + 1'b1;
              end
            end
          end
        end
        ACCUM: begin
          if (chunk_q == LAST_CHUNK) begin
            chunk_q <= '0;
            state_q <= IDLE;
          end else begin
            chunk_q <= chunk_q + 1'b1;
          end
        end
        FINAL: begin
          for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (chunk_q == CIDX_W'(k)) begin
              ns_hv_q[k*CHUNK +: CHUNK] <= w_ns_thr;
              s_hv_q[k*CHUNK +: CHUNK]  <= w_s_thr;
            end
          end
          if (chunk_q == LAST_CHUNK) begin
            chunk_q     <= '0;
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            chunk_q <= chunk_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          chunk_q <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_class_hv_trainer.sv
`default_nettype none
// ============================================================================
// Module      : tb_class_hv_trainer
// Description : Self-checking bench for class_hv_trainer. Two instances (8-bit
//               and 2-bit counters) share one stimulus stream and are compared
//               against an array-based model of the bundling rules.
// Revision    : 1.0  initial release
// ============================================================================
module tb_class_hv_trainer;

  localparam int D = 16;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         nrst;
  logic         in_valid;
  logic         label_in;
  logic         clear;
  logic         finalize;
  logic [D-1:0] hv_in;

  logic         a_in_ready, a_busy, a_out_valid, a_ovf;
  logic [D-1:0] a_ns_hv, a_s_hv;
  logic [7:0]   a_n_ns, a_n_s;
  logic         b_in_ready, b_busy, b_out_valid, b_ovf;
  logic [D-1:0] b_ns_hv, b_s_hv;
  logic [1:0]   b_n_ns, b_n_s;

  always #5 clk = ~clk;

  class_hv_trainer #(.DIMENSIONS(D), .CHUNK(C), .CNT_W(8)) u_dut_a (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(a_in_ready),
    .hv_in(hv_in), .label_in(label_in), .clear(clear), .finalize(finalize),
    .busy(a_busy), .out_valid(a_out_valid), .ns_hv(a_ns_hv), .s_hv(a_s_hv),
    .n_ns(a_n_ns), .n_s(a_n_s), .ovf(a_ovf)
  );

  class_hv_trainer #(.DIMENSIONS(D), .CHUNK(C), .CNT_W(2)) u_dut_b (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(b_in_ready),
    .hv_in(hv_in), .label_in(label_in), .clear(clear), .finalize(finalize),
    .busy(b_busy), .out_valid(b_out_valid), .ns_hv(b_ns_hv), .s_hv(b_s_hv),
    .n_ns(b_n_ns), .n_s(b_n_s), .ovf(b_ovf)
  );

  int checks = 0;
  int errors = 0;

  // Reference model, index [instance][class][dimension].
  int           MAXV [2] = '{255, 3};
  int           cnt_m [2][2][D];
  int           nsmp_m [2][2];
  bit           ovf_m [2];
  logic [D-1:0] hv_m [2][2];
  bit           ov_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 2; c++) begin
        nsmp_m[k][c] = 0;
        hv_m[k][c]   = '0;
        for (int i = 0; i < D; i++) cnt_m[k][c][i] = 0;
      end
      ovf_m[k] = 1'b0;
    end
    ov_m = 1'b0;
  endtask

  task automatic m_clear();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 2; c++) begin
        nsmp_m[k][c] = 0;
        for (int i = 0; i < D; i++) cnt_m[k][c][i] = 0;
      end
      ovf_m[k] = 1'b0;
    end
    ov_m = 1'b0;
  endtask

  task automatic m_accept(input logic [D-1:0] hv, input int l);
    for (int k = 0; k < 2; k++) begin
      if (nsmp_m[k][l] == MAXV[k]) begin
        ovf_m[k] = 1'b1;
      end else begin
        nsmp_m[k][l]++;
        for (int i = 0; i < D; i++) begin
          if (hv[i] && cnt_m[k][l][i] < MAXV[k]) cnt_m[k][l][i]++;
        end
      end
    end
    ov_m = 1'b0;
  endtask

  task automatic m_final();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < D; i++)
          hv_m[k][c][i] = (2 * cnt_m[k][c][i] > nsmp_m[k][c]);
    ov_m = 1'b1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/a_ns_hv"}, a_ns_hv, hv_m[0][0]);
    chk({tag, "/a_s_hv"},  a_s_hv,  hv_m[0][1]);
    chk({tag, "/a_n_ns"},  a_n_ns,  nsmp_m[0][0]);
    chk({tag, "/a_n_s"},   a_n_s,   nsmp_m[0][1]);
    chk({tag, "/a_ovf"},   a_ovf,   ovf_m[0]);
    chk({tag, "/a_ov"},    a_out_valid, ov_m);
    chk({tag, "/b_ns_hv"}, b_ns_hv, hv_m[1][0]);
    chk({tag, "/b_s_hv"},  b_s_hv,  hv_m[1][1]);
    chk({tag, "/b_n_ns"},  b_n_ns,  nsmp_m[1][0]);
    chk({tag, "/b_n_s"},   b_n_s,   nsmp_m[1][1]);
    chk({tag, "/b_ovf"},   b_ovf,   ovf_m[1]);
    chk({tag, "/b_ov"},    b_out_valid, ov_m);
  endtask

  // Accept one sample; optionally pulse clear/finalize while busy (must be ignored).
  task automatic send(input logic [D-1:0] hv, input int l, input bit noise);
    int n;
    hv_in    = hv;
    label_in = l[0];
    in_valid = 1'b1;
    #1;
    chk("ready_before_accept", a_in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    m_accept(hv, l);
    n = 0;
    while (!a_in_ready && n < 20) begin
      if (n == 0) begin
        chk("busy_accum", a_busy, 1);
        clear    = noise;
        finalize = noise;
      end
      tick();
      clear    = 1'b0;
      finalize = 1'b0;
      n++;
    end
    chk("accum_latency", n, 4);
    chk("b_ready_after_accum", b_in_ready, 1);
  endtask

  task automatic do_finalize(input string tag);
    int n;
    finalize = 1'b1;
    #1;
    chk("ready_low_on_finalize", a_in_ready, 0);
    @(posedge clk);
    #1;
    finalize = 1'b0;
    n = 0;
    while (a_busy && n < 20) begin
      tick();
      n++;
    end
    chk("final_latency", n, 4);
    m_final();
    check_all(tag);
  endtask

  task automatic do_clear(input bit with_valid);
    clear    = 1'b1;
    in_valid = with_valid;
    hv_in    = D'($urandom);
    label_in = 1'($urandom);
    #1;
    chk("ready_low_on_clear", a_in_ready, 0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    m_clear();
    chk("clear_not_busy", a_busy, 0);
    check_all("clear");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    nrst = 1'b0; in_valid = 1'b0; label_in = 1'b0; clear = 1'b0; finalize = 1'b0; hv_in = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    tick();
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_busy", a_busy, 0);
    check_all("reset");

    // Single non-seizure sample.
    send(16'hA5A5, 0, 1'b0);
    do_finalize("one_ns");
    chk("one_ns_hv", a_ns_hv, 16'hA5A5);
    chk("one_ns_s_hv", a_s_hv, 16'h0000);
    do_clear(1'b0);

    // Three seizure samples, majority 2 of 3.
    send(16'hF0F0, 1, 1'b1);
    send(16'hFF00, 1, 1'b0);
    send(16'h0FF0, 1, 1'b0);
    do_finalize("three_s");
    chk("three_s_hv", a_s_hv, 16'hFFF0);
    chk("three_s_n", a_n_s, 3);
    do_clear(1'b0);

    // Tie on the upper byte resolves to 0.
    send(16'h00FF, 0, 1'b0);
    send(16'hFFFF, 0, 1'b0);
    do_finalize("tie");
    chk("tie_ns_hv", a_ns_hv, 16'h00FF);
    do_clear(1'b0);

    // Sample counter saturation on the 2-bit instance.
    repeat (4) send(16'hFFFF, 1, 1'b0);
    chk("sat_b_n_s", b_n_s, 3);
    chk("sat_b_ovf", b_ovf, 1);
    chk("sat_a_ovf", a_ovf, 0);
    do_finalize("sat");
    chk("sat_b_s_hv", b_s_hv, 16'hFFFF);
    do_clear(1'b0);
    chk("sat_cleared_ovf", b_ovf, 0);

    // clear wins over a simultaneous sample.
    do_clear(1'b1);

    // Reset during the second accumulation cycle.
    send(16'h1234, 0, 1'b0);
    hv_in = 16'hBEEF; label_in = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tick();
    nrst = 1'b0;
    #1;
    m_reset();
    chk("abort_busy", a_busy, 0);
    check_all("abort");
    @(negedge clk);
    nrst = 1'b1;
    tick();
    chk("abort_ready", a_in_ready, 1);
    check_all("post_abort");

    // Randomised operation mix.
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 6) begin
        send(D'($urandom), $urandom_range(0, 1), 1'($urandom));
        check_all("rnd_send");
      end else if (r <= 8) begin
        do_finalize("rnd_final");
      end else begin
        do_clear(1'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
